npc_predict_unit: RTL and testbench
===================================

Name: npc_predict_unit

Overview:
Parametrised successor to the combinational next-PC selector. Two jobs:
- IF stage: predicts the next PC from a direct-mapped branch-target buffer (BTB) with 2-bit saturating counters.
- EX stage: resolves the actual jump/branch outcome over an extended branch-type set and issues a one-cycle redirect on mispredict.
Also keeps branch and mispredict statistics counters. Sits between the PC register/NPC mux and the EX-stage ALU flags.

Parameters:
PC_W, 32, PC/address width
IDX_W, 4, BTB index bits; BTB depth = 2**IDX_W
CNT_W, 32, statistics counter width
PREDICT_EN, 1, 0 forces pred_taken_f=0 (static not-taken; legacy behaviour)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_f  in  PC_W  IF-stage PC (lookup address)
pred_taken_f  out  1  predict taken for pc_f
pred_target_f  out  PC_W  predicted target (0 when pred_taken_f=0)
ex_valid  in  1  EX holds a valid instruction this cycle
ex_pc  in  PC_W  PC of EX instruction
ex_jump  in  2  0 none, 1 jump-immediate (j/jal), 2 jump-register (jr/jalr)
ex_branch  in  3  branch type, encodings in package
ex_zero  in  1  ALU zero flag
ex_neg  in  1  sign of rs (for blez/bgtz/bltz/bgez)
ex_imm_target  in  PC_W  computed branch/jump-immediate target
ex_reg_target  in  PC_W  register target for jump-register
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
ex_pred_target  in  PC_W  predicted target carried down the pipe
ex_npc_op  out  2  actual outcome in legacy NPCOp encoding
redirect  out  1  mispredict: flush IF/ID, load redirect_pc
redirect_pc  out  PC_W  correct next PC
branch_cnt  out  CNT_W  resolved control-flow instructions
mispred_cnt  out  CNT_W  redirects issued

Behaviour:
- Storage per entry: valid, tag = pc[PC_W-1:IDX_W+2], target, ctr[1:0]. Index = pc[IDX_W+1:2].
- Reset (async, rst_n=0):
  - all valid=0, all ctr=2'b01, branch_cnt=0, mispred_cnt=0.
  - Combinational outputs then read 0: pred_taken_f=0, pred_target_f=0, redirect=0 (ex_valid ignored while rst_n=0).
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken_f = PREDICT_EN & hit & ctr[1].
  - pred_target_f = target when pred_taken_f, else 0.
- Resolve (combinational, only when ex_valid=1):
  - Branch types: beq zero; bne !zero; blez neg|zero; bgtz !neg&!zero; bltz neg; bgez !neg.
  - Priority: jump-immediate > jump-register > branch.
  - Actual target: ex_imm_target for jump-immediate or taken branch; ex_reg_target for jump-register; otherwise ex_pc+4.
  - ex_npc_op = NPC_JUMP_IMM / NPC_JUMP_REG / NPC_BRANCH / NPC_PLUS4.
  - redirect = ex_valid & (taken != ex_pred_taken | (taken & ex_pred_target != actual target)).
  - redirect_pc = actual target. redirect is 0 when ex_valid=0.
- Update (rising clk, ex_valid=1 and (ex_jump!=0 or ex_branch!=0)):
  - Tag hit, branch: ctr saturating +1 if taken, else -1 (11 stays 11, 00 stays 00); target <= ex_imm_target if taken.
  - Tag miss, taken branch: allocate (overwrite) entry, valid=1, target, ctr=2'b10.
  - Tag miss, not-taken branch: no change.
  - Jump-immediate: allocate/refresh entry, ctr=2'b11.
  - Jump-register: never allocated; hit entry (aliasing) invalidated.
  - branch_cnt +1 per update event; mispred_cnt +1 per redirect. Both saturate at all-ones.
- Same-cycle lookup and update of the same index: lookup sees pre-edge state (no bypass).
- rst_n asserted mid-operation clears table and counters immediately; no partial write survives.

Decomposition:
- ctrl_encode_def.v: NPC_* encodings (NPC_PLUS4=0, NPC_BRANCH=1, NPC_JUMP_IMM=2, NPC_JUMP_REG=3) and BR_* encodings (NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6).
- One sub-module: sat_ctr2 (2-bit saturating counter next-state function), instanced per update path.

Test Plan:
- Reset, then pc_f=0x40 -> pred_taken_f=0, pred_target_f=0, branch_cnt=0, mispred_cnt=0.
- beq at ex_pc=0x40, zero=1, imm_target=0x80, pred 0 -> redirect=1, redirect_pc=0x80, ex_npc_op=NPC_BRANCH. Next cycle pc_f=0x40 -> pred_taken_f=1, target 0x80.
- Same branch resolved not-taken, pred 1/0x80 -> redirect=1, redirect_pc=0x44. Lookup 0x40 -> pred_taken_f=0 (ctr 01). Two more not-taken resolves -> ctr stays 00.
- jr at 0x100, reg_target=0x2000, pred 0 -> redirect=1, redirect_pc=0x2000, ex_npc_op=NPC_JUMP_REG, no allocation. j at 0x104 -> entry ctr 11, later pred_taken_f=1.
- Update of index 0 and lookup of pc_f=0x0 in same cycle -> old prediction that cycle, new one next cycle. PREDICT_EN=0 build -> pred_taken_f always 0.
- Drop rst_n mid-stream after 5 redirects -> mispred_cnt=0 and all lookups miss immediately. Force counter to all-ones -> holds.

Source files
------------

// File: rtl/npc_predict_unit_pkg.sv
// npc_predict_unit_pkg: NPC/branch encodings and branch-condition helper
package npc_predict_unit_pkg;
  typedef enum logic [1:0] {
    NPC_PLUS4    = 2'd0,
    NPC_BRANCH   = 2'd1,
    NPC_JUMP_IMM = 2'd2,
    NPC_JUMP_REG = 2'd3
  } npc_op_e;
  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_IMM  = 2'd1,
    JMP_REG  = 2'd2
  } jmp_e;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6
  } br_e;
  function automatic logic br_cond(input logic [2:0] br, input logic zero, input logic neg);
    return br == BR_BEQ  ? zero :
           br == BR_BNE  ? !zero :
           br == BR_BLEZ ? (neg | zero) :
           br == BR_BGTZ ? (!neg & !zero) :
           br == BR_BLTZ ? neg :
           br == BR_BGEZ ? !neg : 1'b0;
  endfunction
endpackage

// File: rtl/npc_predict_unit_sat_ctr2.sv
// sat_ctr2: next state of a 2-bit saturating counter
// Ports: i_ctr current value, i_inc 1=count up / 0=count down, o_ctr next value
module sat_ctr2 (
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_ctr
);
  always_comb o_ctr = i_inc ? (&i_ctr ? i_ctr : i_ctr + 2'd1) : (|i_ctr ? i_ctr - 2'd1 : i_ctr);
endmodule

// File: rtl/npc_predict_unit.sv
// npc_predict_unit: BTB-based next-PC predictor with EX-stage resolve/redirect and statistics
// Ports: clk/rst_n; pc_f -> pred_taken_f/pred_target_f (IF lookup);
//        ex_* resolve inputs -> ex_npc_op, redirect, redirect_pc; branch_cnt, mispred_cnt stats
module npc_predict_unit
  import npc_predict_unit_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 32,
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pc_f,
  output logic             pred_taken_f,
  output logic [PC_W-1:0]  pred_target_f,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [1:0]       ex_jump,
  input  logic [2:0]       ex_branch,
  input  logic             ex_zero,
  input  logic             ex_neg,
  input  logic [PC_W-1:0]  ex_imm_target,
  input  logic [PC_W-1:0]  ex_reg_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic [1:0]       ex_npc_op,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [PC_W-1:0]  r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];
  logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;
  logic [IDX_W-1:0] w_fidx, w_eidx;
  logic [TAG_W-1:0] w_ftag, w_etag;
  logic             w_fhit, w_ehit, w_jimm, w_jreg, w_br, w_taken, w_upd;
  logic [PC_W-1:0]  w_target;
  logic [1:0]       w_ctr_nxt;
  assign w_fidx = pc_f[IDX_W+1:2];
  assign w_ftag = pc_f[PC_W-1:IDX_W+2];
  assign w_eidx = ex_pc[IDX_W+1:2];
  assign w_etag = ex_pc[PC_W-1:IDX_W+2];
  assign w_fhit = r_valid[w_fidx] && r_tag[w_fidx] == w_ftag;
  assign w_ehit = r_valid[w_eidx] && r_tag[w_eidx] == w_etag;
  assign pred_taken_f  = PREDICT_EN && w_fhit && r_ctr[w_fidx][1];
  assign pred_target_f = pred_taken_f ? r_target[w_fidx] : '0;
  assign w_jimm   = ex_jump == JMP_IMM;
  assign w_jreg   = ex_jump == JMP_REG;
  assign w_br     = br_cond(ex_branch, ex_zero, ex_neg);
  assign w_taken  = w_jimm | w_jreg | w_br;
  assign w_target = w_jimm ? ex_imm_target : w_jreg ? ex_reg_target : w_br ? ex_imm_target : ex_pc + PC_W'(4);
  assign w_upd    = ex_valid && (|ex_jump || |ex_branch);
  assign ex_npc_op   = !ex_valid ? NPC_PLUS4 : w_jimm ? NPC_JUMP_IMM : w_jreg ? NPC_JUMP_REG : w_br ? NPC_BRANCH : NPC_PLUS4;
  // Gated by rst_n so a held-valid EX stage cannot redirect during reset
  assign redirect    = rst_n && ex_valid && (w_taken != ex_pred_taken || (w_taken && ex_pred_target != w_target));
  assign redirect_pc = w_target;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;
  sat_ctr2 u_sat_ctr2 (
    .i_ctr (r_ctr[w_eidx]),
    .i_inc (w_br),
    .o_ctr (w_ctr_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else begin
      if (w_upd && !(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (redirect && !(&r_mispred_cnt)) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      if (w_upd) begin
        if (w_jimm) begin
          r_valid[w_eidx]  <= 1'b1;
          r_tag[w_eidx]    <= w_etag;
          r_target[w_eidx] <= ex_imm_target;
          r_ctr[w_eidx]    <= 2'b11;
        end else if (w_jreg) begin
          // Register jumps have no stable target; drop any aliasing entry
          if (w_ehit) r_valid[w_eidx] <= 1'b0;
        end else if (ex_jump == JMP_NONE) begin
          if (w_ehit) begin
            r_ctr[w_eidx] <= w_ctr_nxt;
            if (w_br) r_target[w_eidx] <= ex_imm_target;
          end else if (w_br) begin
            r_valid[w_eidx]  <= 1'b1;
            r_tag[w_eidx]    <= w_etag;
            r_target[w_eidx] <= ex_imm_target;
            r_ctr[w_eidx]    <= 2'b10;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_npc_predict_unit.sv
// tb_npc_predict_unit: scoreboard-based self-checking bench for npc_predict_unit
module tb_npc_predict_unit;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] pc_f = '0, ex_pc = '0, ex_imm_target = '0, ex_reg_target = '0, ex_pred_target = '0;
  logic        ex_valid = 1'b0, ex_zero = 1'b0, ex_neg = 1'b0, ex_pred_taken = 1'b0;
  logic [1:0]  ex_jump = '0;
  logic [2:0]  ex_branch = '0;
  logic        pred_taken_f, redirect, pred_taken2, redirect2;
  logic [31:0] pred_target_f, redirect_pc, branch_cnt, mispred_cnt, pred_target2, redirect_pc2;
  logic [1:0]  ex_npc_op, npc_op2;
  logic [2:0]  bcnt2, mcnt2;
  typedef struct packed {
    logic        rd;
    logic [31:0] pc;
    logic [1:0]  op;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int exp_br = 0, exp_mis = 0;

  always #5 clk = ~clk;

  npc_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_neg(ex_neg), .ex_imm_target(ex_imm_target), .ex_reg_target(ex_reg_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_npc_op(ex_npc_op),
    .redirect(redirect), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  npc_predict_unit #(.CNT_W(3), .PREDICT_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken2), .pred_target_f(pred_target2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_neg(ex_neg), .ex_imm_target(ex_imm_target), .ex_reg_target(ex_reg_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_npc_op(npc_op2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .branch_cnt(bcnt2), .mispred_cnt(mcnt2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic resolve(input logic [1:0] j, input logic [2:0] b, input logic z, input logic n,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rg,
                         input logic pt, input logic [31:0] ptg,
                         input logic erd, input logic [31:0] epc, input logic [1:0] eop, input string nm);
    exp_t e;
    @(negedge clk);
    ex_valid = 1'b1; ex_jump = j; ex_branch = b; ex_zero = z; ex_neg = n; ex_pc = pc;
    ex_imm_target = imm; ex_reg_target = rg; ex_pred_taken = pt; ex_pred_target = ptg;
    sb.push_back('{rd: erd, pc: epc, op: eop});
    if (j != 2'd0 || b != 3'd0) exp_br++;
    if (erd) exp_mis++;
    #2;
    e = sb.pop_front();
    checks += 4;
    if (redirect !== e.rd) begin errors++; $display("FAIL %s redirect got %0b exp %0b", nm, redirect, e.rd); end
    if (redirect2 !== e.rd) begin errors++; $display("FAIL %s redirect(dut2) got %0b exp %0b", nm, redirect2, e.rd); end
    if (redirect_pc !== e.pc) begin errors++; $display("FAIL %s redirect_pc got %h exp %h", nm, redirect_pc, e.pc); end
    if (ex_npc_op !== e.op) begin errors++; $display("FAIL %s ex_npc_op got %0d exp %0d", nm, ex_npc_op, e.op); end
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic et, input logic [31:0] etg, input string nm);
    @(negedge clk);
    pc_f = pc;
    #2;
    checks += 3;
    if (pred_taken_f !== et) begin errors++; $display("FAIL %s pred_taken_f got %0b exp %0b", nm, pred_taken_f, et); end
    if (pred_target_f !== etg) begin errors++; $display("FAIL %s pred_target_f got %h exp %h", nm, pred_target_f, etg); end
    if (pred_taken2 !== 1'b0 || pred_target2 !== 32'h0) begin
      errors++; $display("FAIL %s static-build prediction got %0b/%h exp 0/0", nm, pred_taken2, pred_target2);
    end
  endtask

  task automatic check_cnt(input string nm);
    logic [2:0] sb2, sm2;
    sb2 = exp_br > 7 ? 3'd7 : 3'(exp_br);
    sm2 = exp_mis > 7 ? 3'd7 : 3'(exp_mis);
    checks += 4;
    if (branch_cnt !== 32'(exp_br)) begin errors++; $display("FAIL %s branch_cnt got %0d exp %0d", nm, branch_cnt, exp_br); end
    if (mispred_cnt !== 32'(exp_mis)) begin errors++; $display("FAIL %s mispred_cnt got %0d exp %0d", nm, mispred_cnt, exp_mis); end
    if (bcnt2 !== sb2) begin errors++; $display("FAIL %s branch_cnt(3b) got %0d exp %0d", nm, bcnt2, sb2); end
    if (mcnt2 !== sm2) begin errors++; $display("FAIL %s mispred_cnt(3b) got %0d exp %0d", nm, mcnt2, sm2); end
  endtask

  task automatic test_reset();
    pc_f = 32'h40; ex_valid = 1'b1; ex_jump = 2'd1; ex_pc = 32'h40; ex_imm_target = 32'h80;
    #1 rst_n = 1'b0;
    #2;
    checks += 3;
    if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset pred_taken_f got %0b exp 0", pred_taken_f); end
    if (pred_target_f !== 32'h0) begin errors++; $display("FAIL reset pred_target_f got %h exp 0", pred_target_f); end
    if (redirect !== 1'b0) begin errors++; $display("FAIL reset redirect got %0b exp 0", redirect); end
    check_cnt("reset");
    repeat (2) @(posedge clk);
    #1 ex_valid = 1'b0; ex_jump = 2'd0;
    @(negedge clk) rst_n = 1'b1;
    lookup(32'h40, 1'b0, 32'h0, "reset_lookup");
    check_cnt("reset_after");
  endtask

  task automatic test_branch_learn();
    resolve(2'd0, 3'd1, 1'b1, 1'b0, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 2'd1, "beq_taken_alloc");
    lookup(32'h40, 1'b1, 32'h80, "learn_ctr10");
    resolve(2'd0, 3'd1, 1'b0, 1'b0, 32'h40, 32'h80, 32'h0, 1'b1, 32'h80, 1'b1, 32'h44, 2'd0, "beq_nt_mispred");
    lookup(32'h40, 1'b0, 32'h0, "learn_ctr01");
    resolve(2'd0, 3'd1, 1'b0, 1'b0, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44, 2'd0, "beq_nt_ok1");
    resolve(2'd0, 3'd1, 1'b0, 1'b0, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44, 2'd0, "beq_nt_ok2");
    resolve(2'd0, 3'd1, 1'b1, 1'b0, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 2'd1, "beq_t_from00");
    lookup(32'h40, 1'b0, 32'h0, "learn_ctr00_to01");
    resolve(2'd0, 3'd1, 1'b1, 1'b0, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 2'd1, "beq_t_to10");
    lookup(32'h40, 1'b1, 32'h80, "learn_ctr10_again");
    resolve(2'd0, 3'd1, 1'b1, 1'b0, 32'h40, 32'h80, 32'h0, 1'b1, 32'h80, 1'b0, 32'h80, 2'd1, "beq_correct");
    resolve(2'd0, 3'd1, 1'b1, 1'b0, 32'h40, 32'h90, 32'h0, 1'b1, 32'h80, 1'b1, 32'h90, 2'd1, "beq_wrong_target");
    lookup(32'h40, 1'b1, 32'h90, "learn_new_target");
    lookup(32'h0, 1'b0, 32'h0, "tag_mismatch");
    check_cnt("branch_learn");
  endtask

  task automatic test_branch_types();
    logic [2:0] br [13] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6};
    logic       zz [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       nn [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tk [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 13; k++)
      resolve(2'd0, br[k], zz[k], nn[k], 32'h3C, 32'h600, 32'h700, 1'b0, 32'h0,
              tk[k], tk[k] ? 32'h600 : 32'h40, tk[k] ? 2'd1 : 2'd0, $sformatf("brtype_%0d", k));
    resolve(2'd1, 3'd1, 1'b0, 1'b0, 32'h3C, 32'h600, 32'h700, 1'b0, 32'h0, 1'b1, 32'h600, 2'd2, "prio_jimm");
    resolve(2'd2, 3'd2, 1'b0, 1'b0, 32'h3C, 32'h600, 32'h700, 1'b0, 32'h0, 1'b1, 32'h700, 2'd3, "prio_jreg");
    @(negedge clk);
    ex_valid = 1'b0; ex_jump = 2'd1; ex_pc = 32'h3C; ex_pred_taken = 1'b0;
    #2;
    checks++;
    if (redirect !== 1'b0) begin errors++; $display("FAIL invalid_ex redirect got %0b exp 0", redirect); end
    @(posedge clk);
    #1 ex_jump = 2'd0;
    check_cnt("branch_types");
  endtask

  task automatic test_jumps();
    resolve(2'd2, 3'd0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h2000, 1'b0, 32'h0, 1'b1, 32'h2000, 2'd3, "jr_miss");
    lookup(32'h100, 1'b0, 32'h0, "jr_no_alloc");
    lookup(32'h40, 1'b1, 32'h90, "jr_no_alias_damage");
    resolve(2'd1, 3'd0, 1'b0, 1'b0, 32'h104, 32'h3000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3000, 2'd2, "j_alloc");
    lookup(32'h104, 1'b1, 32'h3000, "j_ctr11");
    resolve(2'd2, 3'd0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h500, 1'b1, 32'h3000, 1'b1, 32'h500, 2'd3, "jr_alias");
    lookup(32'h104, 1'b0, 32'h0, "jr_invalidated");
    resolve(2'd1, 3'd0, 1'b0, 1'b0, 32'h104, 32'h3000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3000, 2'd2, "j_realloc");
    lookup(32'h104, 1'b1, 32'h3000, "j_refresh");
    check_cnt("jumps");
  endtask

  task automatic test_same_cycle();
    @(negedge clk) pc_f = 32'h0;
    fork
      resolve(2'd0, 3'd1, 1'b1, 1'b0, 32'h0, 32'h700, 32'h0, 1'b0, 32'h0, 1'b1, 32'h700, 2'd1, "same_cycle_upd");
      begin
        @(negedge clk);
        #3;
        checks++;
        if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL same_cycle_old got %0b exp 0", pred_taken_f); end
      end
    join
    checks += 2;
    if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL same_cycle_new taken got %0b exp 1", pred_taken_f); end
    if (pred_target_f !== 32'h700) begin errors++; $display("FAIL same_cycle_new target got %h exp 700", pred_target_f); end
    lookup(32'h40, 1'b0, 32'h0, "overwritten_entry");
    check_cnt("same_cycle_saturated");
    resolve(2'd1, 3'd0, 1'b0, 1'b0, 32'h108, 32'h900, 32'h0, 1'b0, 32'h0, 1'b1, 32'h900, 2'd2, "sat_hold");
    check_cnt("saturation_hold");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++)
      resolve(2'd1, 3'd0, 1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h800, 32'h0, 1'b0, 32'h0, 1'b1, 32'h800, 2'd2, "pre_reset_j");
    lookup(32'h500, 1'b1, 32'h800, "pre_reset_hit");
    @(negedge clk);
    ex_valid = 1'b1; ex_jump = 2'd1; ex_pc = 32'h500; ex_imm_target = 32'hA00; ex_pred_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (mispred_cnt !== 32'h0) begin errors++; $display("FAIL midreset mispred_cnt got %0d exp 0", mispred_cnt); end
    if (branch_cnt !== 32'h0) begin errors++; $display("FAIL midreset branch_cnt got %0d exp 0", branch_cnt); end
    if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL midreset pred_taken_f got %0b exp 0", pred_taken_f); end
    if (redirect !== 1'b0) begin errors++; $display("FAIL midreset redirect got %0b exp 0", redirect); end
    @(posedge clk);
    #1 ex_valid = 1'b0; ex_jump = 2'd0;
    exp_br = 0; exp_mis = 0;
    @(negedge clk) rst_n = 1'b1;
    lookup(32'h500, 1'b0, 32'h0, "post_reset_miss");
    lookup(32'h504, 1'b0, 32'h0, "post_reset_miss2");
    check_cnt("post_reset");
    resolve(2'd1, 3'd0, 1'b0, 1'b0, 32'h500, 32'h800, 32'h0, 1'b0, 32'h0, 1'b1, 32'h800, 2'd2, "post_reset_j");
    lookup(32'h500, 1'b1, 32'h800, "post_reset_relearn");
    check_cnt("post_reset_count");
  endtask

  initial begin
    test_reset();
    test_branch_learn();
    test_branch_types();
    test_jumps();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
